// File: rtl/pes_demux_pkg.sv
// Shared constants and state type for the 1:8 demux collector.
package pes_demux_pkg;
  localparam int PES_NCH   = 8;
  localparam int PES_SEL_W = 3;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } collect_state_t;
endpackage

// File: rtl/pes_demux_collect_8_idle_timer.sv
// Idle down-counter: expire pulses on the last of TIMEOUT_CYC
// consecutive enabled cycles; TIMEOUT_CYC=0 disables it.
module pes_idle_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  generate
    if (TIMEOUT_CYC > 0) begin : g_on
      localparam int W = $clog2(TIMEOUT_CYC + 1);
      localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 1);
      localparam bit ONE_CYC = (TIMEOUT_CYC == 1);
      logic [W-1:0] cnt;

      // cnt==0 means not yet armed; the first idle cycle loads it
      assign expire = enable &&
        ((cnt == W'(1)) || (ONE_CYC && cnt == '0));

      always_ff @(posedge clk) begin
        if (rst || clear || expire)
          cnt <= '0;
        else if (enable)
          cnt <= (cnt == '0) ? LOAD : cnt - W'(1);
      end
    end else begin : g_off
      assign expire = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/pes_demux_collect_8.sv
// Collects routed demux bits into a byte and offers it on a
// valid/ready port; flags duplicates, non-one-hot input, stalls.
module pes_demux_collect_8
  import pes_demux_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PES_NCH-1:0]   d,
  input  logic [PES_SEL_W-1:0] sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PES_NCH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PES_NCH-1:0]   mask,
  output logic                 err_dup,
  output logic                 err_onehot,
  output logic                 err_timeout
);
  collect_state_t     state;
  logic [PES_NCH-1:0] data_reg;
  logic [PES_NCH-1:0] hit;
  logic [PES_NCH-1:0] mask_nx;
  logic               accept;
  logic               t_clear;
  logic               t_en;
  logic               expire;

  assign in_ready  = (state == ST_COLLECT) && !rst;
  assign out_valid = (state == ST_FULL);
  assign out_data  = data_reg;
  assign accept    = in_valid && in_ready;
  assign hit       = PES_NCH'(1) << sel;
  assign mask_nx   = mask | hit;

  assign t_en    = (state == ST_COLLECT) && (mask != '0) && !accept;
  assign t_clear = accept || (mask == '0) || (state != ST_COLLECT);

  pes_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (t_clear),
    .enable (t_en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_COLLECT;
      mask        <= '0;
      data_reg    <= '0;
      err_dup     <= 1'b0;
      err_onehot  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_dup     <= accept && ((mask & hit) != '0);
      err_onehot  <= accept && ((d & ~hit) != '0);
      err_timeout <= expire;
      unique case (state)
        ST_COLLECT: begin
          if (accept) begin
            data_reg[sel] <= d[sel];
            mask          <= mask_nx;
            if (mask_nx == '1)
              state <= ST_FULL;
          end else if (expire) begin
            mask     <= '0;
            data_reg <= '0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state    <= ST_COLLECT;
            mask     <= '0;
            data_reg <= '0;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end
endmodule

// File: doc/pes_demux_collect_8.md
# pes_demux_collect_8

Downstream collector for the 1:8 bit demultiplexer. The demux drives only the selected output and forces the other seven to 0, so each bit is visible only while its select is active. This block latches each routed bit into its position, tracks which positions have been written, and presents the assembled byte on a valid/ready output port. It also flags duplicate writes, non-one-hot demux outputs, and stalled partial frames.

## Interface
- `TIMEOUT_CYC`, default 16: idle cycles allowed with a partial frame before it is dropped; 0 disables the timeout.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d`  in  8  demux outputs packed {o7,o6,o5,o4,o3,o2,o1,o0}.
- `sel`  in  3  select value currently driving the demux.
- `in_valid`  in  1  `sel`/`d` are meaningful this cycle.
- `in_ready`  out  1  collector can accept a bit this cycle.
- `out_data`  out  8  assembled byte; bit k came from `o`k.
- `out_valid`  out  1  `out_data` holds a complete byte.
- `out_ready`  in  1  consumer takes the byte.
- `mask`  out  8  positions written in the current frame.
- `err_dup`  out  1  one-cycle pulse: a position was written twice in one frame.
- `err_onehot`  out  1  one-cycle pulse: an accepted `d` had a nonzero bit outside `sel`.
- `err_timeout`  out  1  one-cycle pulse: a partial frame was dropped.

## Operation
- FSM states:
  - COLLECT (reset state): `in_ready`=1, `out_valid`=0.
  - FULL: `in_ready`=0, `out_valid`=1.
- Accept condition: `in_valid && in_ready`. On accept:
  - `data_reg[sel]` <= `d[sel]`; `mask[sel]` <= 1.
  - `err_onehot` pulses when `(d & ~(8'b1 << sel)) != 0`. The bit at `sel` is still captured.
  - If `mask[sel]` was already 1, `err_dup` pulses, the bit is overwritten with the new value, and `mask` is unchanged.
- COLLECT -> FULL on the cycle after the accept that makes `mask` == 8'hFF. Order of positions is irrelevant.
- FULL -> COLLECT when `out_valid && out_ready`. On that edge `mask` and `data_reg` clear to 0.
- There is no bypass: the first bit of the next frame is accepted at the earliest one cycle after the handshake.
- Timeout, when `TIMEOUT_CYC` > 0:
  - The idle counter runs only in COLLECT with `mask` != 0.
  - It resets on every accept and is held at 0 while `mask` == 0.
  - After `TIMEOUT_CYC` consecutive non-accept cycles, `mask` and `data_reg` clear and `err_timeout` pulses on the next cycle.
  - Counter width: $clog2(TIMEOUT_CYC+1).
- Simultaneous events:
  - An accept in the expiry cycle wins: no timeout, and the counter resets.
  - `err_dup` and `err_onehot` may pulse in the same cycle.
- Reset, including mid-frame:
  - Partial data is discarded.
  - Next cycle: state COLLECT, `mask`=0, `out_data`=0, `out_valid`=0, all `err_*`=0, counter=0.
  - `in_ready`=0 during every cycle `rst` is high, and 1 on the first cycle after.

## Timing
- Bit capture latency is 1 cycle: `mask`/`data_reg` update at the edge ending the accept cycle.
- Byte latency: `out_valid` rises 1 cycle after the 8th distinct accept.
- Minimum frame period is 9 cycles at full rate: 8 accepts, then 1 FULL cycle with `out_ready`=1.
- While FULL, `out_data` is stable and `in_ready` stays 0 regardless of `in_valid`, for as long as `out_ready` is low.
- `out_data` mirrors `data_reg` and holds its last value while not valid.
- All error pulses are registered and appear 1 cycle after the causing accept or expiry.

## Structure
- Package `pes_demux_pkg` holds:
  - constants `PES_NCH`=8 and `PES_SEL_W`=3;
  - the state typedef `collect_state_t` with values `ST_COLLECT` and `ST_FULL`.
- One sub-module, `pes_idle_timer`. It is a parameterised down-counter with `clear`, `enable` and `expire` pulse, and `TIMEOUT_CYC`=0 ties `expire` low.
- All remaining logic is a single FSM plus the data/mask registers.

## Test plan
- Reset, then sel 0..7 in order with `d`=8'h01,8'h00,8'h04,8'h00,8'h10,8'h00,8'h40,8'h00 and `out_ready`=1 -> `out_valid`=1 for one cycle with `out_data`=8'h55, 1 cycle after the last accept; `mask` returns to 0.
- Out-of-order sel 7,3,0,5,1,6,2,4, all bits 1, `out_ready`=0 for 5 cycles -> `out_data`=8'hFF held; `in_ready`=0 throughout the stall; handshake on the 6th cycle.
- sel=2 `d`=8'h04, then sel=2 `d`=8'h00 -> `err_dup` pulse; `mask`=8'h04 and `data_reg[2]`=0.
- Accept sel=1 with `d`=8'h03 -> `err_onehot` pulse; captured bit is 1; `mask`=8'h02.
- With `TIMEOUT_CYC`=16: 3 accepts, then 16 idle cycles -> `err_timeout` pulse and `mask`=0. A repeat with an accept on the 16th idle cycle -> no timeout.
- Assert `rst` after 5 accepts -> `mask`=0, `out_valid`=0, `in_ready`=0 while `rst` is high; a full new frame then completes normally.
